lbist_ctrl: RTL

// Logic-BIST controller; the responder side of the testbench start/go_nogo handshake.
// It sits inside riscv_wrapper between the tb start/go_nogo pins and the core's scan chains.
// A rising edge on start runs a fixed LFSR-driven scan test and compacts the chain outputs in a MISR.
// It then compares the signature with a golden value and reports pass/fail on go_nogo.

---
 rtl/lbist_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lbist_ctrl.sv
// Logic-BIST controller: answers the start/go_nogo handshake by running an LFSR-driven
// scan test, compacting chain outputs in a MISR and comparing against a golden signature.
module lbist_ctrl #(
  parameter int unsigned         N_CHAINS   = 8,
  parameter int unsigned         CHAIN_LEN  = 64,
  parameter int unsigned         N_PATTERNS = 1024,
  parameter int unsigned         LFSR_W     = 32,
  parameter int unsigned         MISR_W     = 32,
  parameter logic [LFSR_W-1:0]   LFSR_SEED  = 32'h1,
  parameter logic [LFSR_W-1:0]   LFSR_POLY  = 32'h8020_0003,
  parameter logic [MISR_W-1:0]   MISR_POLY  = 32'h04C1_1DB7,
  parameter logic [MISR_W-1:0]   GOLDEN_SIG = 32'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                test_mode_o,
  output logic                scan_en_o,
  output logic [N_CHAINS-1:0] scan_in_o,
  input  logic [N_CHAINS-1:0] scan_out_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                go_nogo,
  output logic [MISR_W-1:0]   signature_o
);

  localparam int unsigned SH_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned PAT_W = $clog2(N_PATTERNS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_start_q;
  logic                w_trig;
  logic [SH_W-1:0]     r_sh_cnt;
  logic [PAT_W-1:0]    r_pat_cnt;
  logic                w_sh_last;
  logic                w_pat_last;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [LFSR_W-1:0]   w_lfsr_adv;
  logic [LFSR_W-1:0]   w_lfsr_nxt;
  logic [MISR_W-1:0]   r_misr;
  logic [MISR_W-1:0]   w_misr_adv;
  logic [MISR_W-1:0]   w_misr_nxt;
  logic                w_busy_nxt;
  logic                w_scan_en_nxt;
  logic [N_CHAINS-1:0] w_scan_in_nxt;
  logic                w_done_nxt;
  logic                w_go_nxt;

  // Rising-edge detect on the run request; a held level never retriggers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_start_q <= 1'b0;
    else        r_start_q <= start;
  end

  assign w_trig     = start & ~r_start_q;
  assign w_sh_last  = (r_sh_cnt == SH_W'(CHAIN_LEN - 1));
  assign w_pat_last = (r_pat_cnt == PAT_W'(N_PATTERNS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_trig) w_state_nxt = INIT;
      INIT:       w_state_nxt = SHIFT;
      SHIFT:      if (w_sh_last) w_state_nxt = CAPTURE;
      CAPTURE:    w_state_nxt = w_pat_last ? UNLOAD : SHIFT;
      UNLOAD:     if (w_sh_last) w_state_nxt = COMPARE;
      COMPARE:    w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // TPG LFSR and MISR next values; pattern 0 unload is stale chain content, so it is not compacted.
  always_comb begin
    w_lfsr_adv = {r_lfsr[LFSR_W-2:0], 1'b0} ^ (r_lfsr[LFSR_W-1] ? LFSR_POLY : '0);
    w_misr_adv = {r_misr[MISR_W-2:0], 1'b0} ^ (r_misr[MISR_W-1] ? MISR_POLY : '0)
                 ^ MISR_W'(scan_out_i);
    w_lfsr_nxt = r_lfsr;
    w_misr_nxt = r_misr;
    case (r_state)
      INIT: begin
        w_lfsr_nxt = LFSR_SEED;
        w_misr_nxt = '0;
      end
      SHIFT: begin
        w_lfsr_nxt = w_lfsr_adv;
        if (r_pat_cnt != '0) w_misr_nxt = w_misr_adv;
      end
      UNLOAD:  w_misr_nxt = w_misr_adv;
      default: ;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered copies line up with it.
  always_comb begin
    w_busy_nxt    = 1'b0;
    w_scan_en_nxt = 1'b0;
    w_scan_in_nxt = '0;
    w_done_nxt    = 1'b0;
    w_go_nxt      = go_nogo;
    case (w_state_nxt)
      INIT, CAPTURE, COMPARE: w_busy_nxt = 1'b1;
      SHIFT: begin
        w_busy_nxt    = 1'b1;
        w_scan_en_nxt = 1'b1;
        w_scan_in_nxt = w_lfsr_nxt[N_CHAINS-1:0];
      end
      UNLOAD: begin
        w_busy_nxt    = 1'b1;
        w_scan_en_nxt = 1'b1;
      end
      DONE:    w_done_nxt = 1'b1;
      default: ;
    endcase
    if (r_state == INIT)    w_go_nxt = 1'b0;
    if (r_state == COMPARE) w_go_nxt = (r_misr == GOLDEN_SIG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o      <= 1'b0;
      test_mode_o <= 1'b0;
      scan_en_o   <= 1'b0;
      scan_in_o   <= '0;
      done_o      <= 1'b0;
      go_nogo     <= 1'b0;
    end else begin
      busy_o      <= w_busy_nxt;
      test_mode_o <= w_busy_nxt;
      scan_en_o   <= w_scan_en_nxt;
      scan_in_o   <= w_scan_in_nxt;
      done_o      <= w_done_nxt;
      go_nogo     <= w_go_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr    <= LFSR_SEED;
      r_misr    <= '0;
      r_sh_cnt  <= '0;
      r_pat_cnt <= '0;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      r_misr <= w_misr_nxt;
      case (r_state)
        INIT: begin
          r_sh_cnt  <= '0;
          r_pat_cnt <= '0;
        end
        SHIFT, UNLOAD: r_sh_cnt <= w_sh_last ? '0 : r_sh_cnt + SH_W'(1);
        CAPTURE:       r_pat_cnt <= w_pat_last ? '0 : r_pat_cnt + PAT_W'(1);
        default: ;
      endcase
    end
  end

  assign signature_o = r_misr;

endmodule
